// File: rtl/conv_pkg.sv
// Shared types and constants for the complex accumulator array.
package conv_pkg;

  // Component width baked into complex_t.
  localparam int unsigned CPLX_W = 32;
  // Each dimension of the [0:3][0:3][0:3] lane array.
  localparam int unsigned DIM = 4;

  typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
  } complex_t;

  // Burst framing state held by the top level.
  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } acc_state_t;

endpackage

// File: rtl/complex_accumulator_lane.sv
// One complex accumulator lane: running sum register plus registered result.
// Build option ACC_SATURATE_EN makes the running add saturate instead of wrap.
module complex_accumulator_lane
  import conv_pkg::*;
#(
  // Must match CPLX_W; complex_t fixes the port width.
  parameter int unsigned DATA_WIDTH = CPLX_W
) (
  input  logic     clk,
  input  logic     reset,
  input  complex_t in,
  input  logic     load,
  input  logic     accum,
  input  logic     capture,
  output complex_t out
);

  complex_t acc_q;
  complex_t acc_d;
  complex_t out_q;

`ifdef ACC_SATURATE_EN
  // Signed add clamped to the representable range.
  function automatic logic signed [DATA_WIDTH-1:0] add_comp(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      // Sign bit of the wide sum tells which rail was crossed.
      add_comp = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      add_comp = sum[DATA_WIDTH-1:0];
    end
  endfunction
`else
  // Plain modulo-2^DATA_WIDTH add.
  function automatic logic signed [DATA_WIDTH-1:0] add_comp(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    add_comp = a + b;
  endfunction
`endif

  // Next running sum: load on burst start, add while accumulating, else hold.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = in;
    end else if (accum) begin
      acc_d.r = add_comp(acc_q.r, in.r);
      acc_d.i = add_comp(acc_q.i, in.i);
    end
  end

  // Running sum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Result register captures the pre-load sum, so a coincident start is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (capture) begin
      out_q <= acc_q;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/complex_accumulator_array_parallel.sv
// 64-lane complex accumulator array; owns burst framing and output_valid.
// Build option ACC_SATURATE_EN selects saturating accumulation in every lane.
module complex_accumulator_array_parallel
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CPLX_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  complex_t [0:DIM-1][0:DIM-1][0:DIM-1] in,
  input  logic                           start,
  input  logic                           stop,
  output complex_t [0:DIM-1][0:DIM-1][0:DIM-1] out,
  output logic                           output_valid
);

  acc_state_t state_q;
  logic       output_valid_q;
  logic       capture;
  logic       load;
  logic       accum;

  // Lane controls; stop while idle does nothing, stop never adds.
  always_comb begin
    capture = stop && (state_q == StAccum);
    load    = start;
    accum   = (state_q == StAccum) && !start && !stop;
  end

  // Burst state and one-cycle result strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      output_valid_q <= 1'b0;
    end else begin
      output_valid_q <= capture;
      if (start) begin
        state_q <= StAccum;
      end else if (capture) begin
        state_q <= StIdle;
      end
    end
  end

  assign output_valid = output_valid_q;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_i
    for (genvar gj = 0; gj < DIM; gj++) begin : g_j
      for (genvar gk = 0; gk < DIM; gk++) begin : g_k
        complex_accumulator_lane #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
          .clk     (clk),
          .reset   (reset),
          .in      (in[gi][gj][gk]),
          .load    (load),
          .accum   (accum),
          .capture (capture),
          .out     (out[gi][gj][gk])
        );
      end
    end
  end

endmodule

// File: tb/tb_complex_accumulator_array_parallel.sv
// Directed, table-driven bench for complex_accumulator_array_parallel.
module tb_complex_accumulator_array_parallel;
  import conv_pkg::*;

  typedef struct {
    logic start;
    logic stop;
    int   r;
    int   i;
    logic exp_ov;
    int   exp_r;
    int   exp_i;
  } vec_t;

`ifdef ACC_SATURATE_EN
  localparam int OVF_R = 32'h7FFFFFFF;
`else
  localparam int OVF_R = -2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic stop;
  logic output_valid;
  complex_t [0:3][0:3][0:3] in_s;
  complex_t [0:3][0:3][0:3] out_s;

  int errors = 0;
  int checks = 0;

  vec_t vecs [24];

  complex_accumulator_array_parallel dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in_s),
    .start        (start),
    .stop         (stop),
    .out          (out_s),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(input int r, input int i);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++) begin
          in_s[a][b][c].r = r;
          in_s[a][b][c].i = i;
        end
  endtask

  // Lane index value a*16+b*4+c on r, its negation on i.
  task automatic set_indexed();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++) begin
          in_s[a][b][c].r = a * 16 + b * 4 + c;
          in_s[a][b][c].i = -(a * 16 + b * 4 + c);
        end
  endtask

  // Number of lanes whose out differs from expectation.
  function automatic int bad_lanes(input bit indexed, input int er, input int ei);
    int n = 0;
    int xr;
    int xi;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++) begin
          xr = indexed ? 3 * (a * 16 + b * 4 + c) : er;
          xi = indexed ? -3 * (a * 16 + b * 4 + c) : ei;
          if (out_s[a][b][c].r !== xr || out_s[a][b][c].i !== xi) n++;
        end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           start stop  r             i     ov    exp_r  exp_i
    vecs[0]  = '{1'b1, 1'b0, 1,            -2,   1'b0, 0,     0};
    vecs[1]  = '{1'b0, 1'b0, 3,            -2,   1'b0, 0,     0};
    vecs[2]  = '{1'b0, 1'b0, 5,            -2,   1'b0, 0,     0};
    vecs[3]  = '{1'b0, 1'b0, 7,            -2,   1'b0, 0,     0};
    vecs[4]  = '{1'b0, 1'b1, 999,          999,  1'b1, 16,    -8};
    vecs[5]  = '{1'b0, 1'b0, 0,            0,    1'b0, 16,    -8};
    vecs[6]  = '{1'b1, 1'b0, 100,          200,  1'b0, 16,    -8};
    vecs[7]  = '{1'b0, 1'b1, 999,          999,  1'b1, 100,   200};
    vecs[8]  = '{1'b0, 1'b0, 0,            0,    1'b0, 100,   200};
    vecs[9]  = '{1'b1, 1'b0, 10,           0,    1'b0, 100,   200};
    vecs[10] = '{1'b0, 1'b0, 10,           0,    1'b0, 100,   200};
    vecs[11] = '{1'b1, 1'b1, 1,            0,    1'b1, 20,    0};
    vecs[12] = '{1'b0, 1'b0, 1,            0,    1'b0, 20,    0};
    vecs[13] = '{1'b0, 1'b0, 1,            0,    1'b0, 20,    0};
    vecs[14] = '{1'b0, 1'b1, 999,          999,  1'b1, 3,     0};
    vecs[15] = '{1'b0, 1'b1, 999,          999,  1'b0, 3,     0};
    vecs[16] = '{1'b1, 1'b0, 32'h7FFFFFFF, 0,    1'b0, 3,     0};
    vecs[17] = '{1'b0, 1'b0, 32'h7FFFFFFF, 0,    1'b0, 3,     0};
    vecs[18] = '{1'b0, 1'b1, 0,            0,    1'b1, OVF_R, 0};
    vecs[19] = '{1'b0, 1'b0, 0,            0,    1'b0, OVF_R, 0};
    vecs[20] = '{1'b1, 1'b0, 5,            5,    1'b0, OVF_R, 0};
    vecs[21] = '{1'b1, 1'b0, 2,            3,    1'b0, OVF_R, 0};
    vecs[22] = '{1'b0, 1'b0, 1,            1,    1'b0, OVF_R, 0};
    vecs[23] = '{1'b0, 1'b1, 999,          999,  1'b1, 3,     4};

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    set_all(0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("reset output_valid", output_valid, 0);
    chk("reset out lanes bad", bad_lanes(1'b0, 0, 0), 0);

    for (int n = 0; n < 24; n++) begin
      start = vecs[n].start;
      stop  = vecs[n].stop;
      set_all(vecs[n].r, vecs[n].i);
      tick();
      chk($sformatf("row%0d output_valid", n), output_valid, vecs[n].exp_ov);
      chk($sformatf("row%0d lane333.r", n), out_s[3][3][3].r, vecs[n].exp_r);
      chk($sformatf("row%0d lanes bad", n), bad_lanes(1'b0, vecs[n].exp_r, vecs[n].exp_i), 0);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Reset mid-burst: everything clears and a later stop is ignored.
    start = 1'b1;
    set_all(4, 4);
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("midreset output_valid", output_valid, 0);
    chk("midreset out lanes bad", bad_lanes(1'b0, 0, 0), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("midreset stop no pulse", output_valid, 0);
    tick();
    chk("midreset later no pulse", output_valid, 0);
    chk("midreset out still zero", bad_lanes(1'b0, 0, 0), 0);

    // Lane independence: each lane sums its own index three times.
    set_indexed();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    set_all(999, 999);
    tick();
    chk("indexed output_valid", output_valid, 1);
    chk("indexed lane333.r", out_s[3][3][3].r, 189);
    chk("indexed lanes bad", bad_lanes(1'b1, 0, 0), 0);
    // Stop while idle: no pulse, result held.
    tick();
    chk("idle stop no pulse", output_valid, 0);
    stop = 1'b0;
    tick();
    chk("idle stop still no pulse", output_valid, 0);
    chk("idle stop out held", bad_lanes(1'b1, 0, 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
